// File: rtl/box_catch_inventory.sv
// Player-side catch detector and box inventory: pulses box_caught back to the spawner,
// counts carried boxes up to CAPACITY and banks them into score inside the drop zone.
module box_catch_inventory #(
  parameter logic [2:0] CAPACITY       = 3'd3,
  parameter logic [7:0] CATCH_COOLDOWN = 8'd10,
  parameter logic [9:0] DROP_X_MAX     = 10'd60,
  parameter logic [7:0] DEPOSIT_CYCLES = 8'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        box_active,
  input  logic [9:0]  box_x_pos,
  input  logic [9:0]  box_y_pos,
  input  logic [9:0]  box_width,
  input  logic [9:0]  box_height,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  player_w,
  input  logic [9:0]  player_h,
  output logic        box_caught,
  output logic        player_is_holding_box,
  output logic [2:0]  held_count,
  output logic [15:0] score,
  output logic        deposit_pulse
);

  typedef enum logic [1:0] {
    S_READY    = 2'd0,
    S_CAUGHT   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cooldown;
  logic [7:0] dwell;

  // Edge sums widened to 11 bits so boxes near the right/bottom border cannot wrap.
  logic [10:0] player_right, player_bottom, box_right, box_bottom;
  logic        hit, full, in_zone, deposit_now, catch_now;

  assign player_right  = {1'b0, player_x}  + {1'b0, player_w};
  assign player_bottom = {1'b0, player_y}  + {1'b0, player_h};
  assign box_right     = {1'b0, box_x_pos} + {1'b0, box_width};
  assign box_bottom    = {1'b0, box_y_pos} + {1'b0, box_height};

  assign hit = box_active
            && ({1'b0, box_x_pos} < player_right)
            && ({1'b0, player_x}  < box_right)
            && ({1'b0, box_y_pos} < player_bottom)
            && ({1'b0, player_y}  < box_bottom);

  assign full                  = (held_count == CAPACITY);
  assign player_is_holding_box = full;
  assign in_zone               = (player_x < DROP_X_MAX) && (held_count != 3'd0);
  assign deposit_now           = in_zone && (dwell == DEPOSIT_CYCLES - 8'd1);
  assign catch_now             = (state == S_READY) && hit && !full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_READY;
      cooldown      <= 8'd0;
      dwell         <= 8'd0;
      held_count    <= 3'd0;
      score         <= 16'd0;
      box_caught    <= 1'b0;
      deposit_pulse <= 1'b0;
    end else if (!game_en) begin
      box_caught    <= 1'b0;
      deposit_pulse <= 1'b0;
    end else begin
      box_caught    <= catch_now;
      deposit_pulse <= deposit_now;

      case (state)
        S_READY: begin
          if (catch_now) state <= S_CAUGHT;
        end
        S_CAUGHT: begin
          cooldown <= 8'd0;
          state    <= S_COOLDOWN;
        end
        S_COOLDOWN: begin
          // Counter parks at the limit until the spawner has dropped the box.
          if (cooldown == CATCH_COOLDOWN) begin
            if (!box_active) state <= S_READY;
          end else begin
            cooldown <= cooldown + 8'd1;
          end
        end
        default: state <= S_READY;
      endcase

      // Catch and deposit may land on the same edge; both apply.
      held_count <= held_count + {2'b00, catch_now} - {2'b00, deposit_now};
      if (deposit_now && (score != 16'hFFFF)) score <= score + 16'd1;
      dwell <= (in_zone && !deposit_now) ? dwell + 8'd1 : 8'd0;
    end
  end

endmodule

// File: tb/tb_box_catch_inventory.sv
// Self-checking bench for box_catch_inventory: directed scenarios plus randomized
// stimulus compared against an elapsed-cycle reference model.
module tb_box_catch_inventory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        game_en = 1'b0;
  logic        box_active = 1'b0;
  logic [9:0]  box_x_pos = 10'd0, box_y_pos = 10'd0, box_width = 10'd0, box_height = 10'd0;
  logic [9:0]  player_x = 10'd0, player_y = 10'd0, player_w = 10'd0, player_h = 10'd0;
  logic        box_caught, player_is_holding_box, deposit_pulse;
  logic [2:0]  held_count;
  logic [15:0] score;

  box_catch_inventory dut (
    .clk(clk), .rst(rst), .game_en(game_en), .box_active(box_active),
    .box_x_pos(box_x_pos), .box_y_pos(box_y_pos), .box_width(box_width), .box_height(box_height),
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .box_caught(box_caught), .player_is_holding_box(player_is_holding_box),
    .held_count(held_count), .score(score), .deposit_pulse(deposit_pulse)
  );

  always #5 clk = ~clk;

  localparam int CAP   = 3;
  localparam int CD    = 10;
  localparam int DROPX = 60;
  localparam int DEP   = 15;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: edges elapsed since the last catch decide when catching is allowed again.
  int m_held, m_score, m_since, m_dwell;
  bit m_busy, m_caught, m_dep;

  logic [21:0] dut_vec;
  assign dut_vec = {box_caught, deposit_pulse, held_count, score, player_is_holding_box};

  function automatic logic [21:0] model_vec();
    logic [2:0]  h = 3'(m_held);
    logic [15:0] s = 16'(m_score);
    logic        f = (m_held == CAP);
    return {m_caught, m_dep, h, s, f};
  endfunction

  function automatic bit model_hit();
    int px = int'(player_x), py = int'(player_y), pw = int'(player_w), ph = int'(player_h);
    int bx = int'(box_x_pos), by = int'(box_y_pos), bw = int'(box_width), bh = int'(box_height);
    return box_active && (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);
  endfunction

  task automatic model_reset();
    m_held = 0; m_score = 0; m_since = 0; m_dwell = 0;
    m_busy = 0; m_caught = 0; m_dep = 0;
  endtask

  task automatic model_edge();
    bit catch_ev, dep_ev, zone;
    if (!game_en) begin
      m_caught = 0; m_dep = 0;
      return;
    end
    catch_ev = !m_busy && model_hit() && (m_held < CAP);
    zone     = (int'(player_x) < DROPX) && (m_held > 0);
    dep_ev   = zone && (m_dwell == DEP - 1);
    if (m_busy) begin
      // Busy for one handoff edge plus CD counting edges, then until the box is gone.
      if (m_since >= CD + 1 && !box_active) m_busy = 0;
      else m_since++;
    end
    if (catch_ev) begin m_busy = 1; m_since = 0; end
    m_dwell  = zone ? (dep_ev ? 0 : m_dwell + 1) : 0;
    m_held   = m_held + int'(catch_ev) - int'(dep_ev);
    if (dep_ev && m_score < 65535) m_score++;
    m_caught = catch_ev;
    m_dep    = dep_ev;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (box_caught || deposit_pulse)
      $display("t=%0t caught=%0b deposit=%0b held=%0d score=%0d", $time, box_caught, deposit_pulse, held_count, score);
  endtask

  task automatic set_defaults();
    game_en = 1'b1; box_active = 1'b0;
    player_x = 10'd100; player_y = 10'd285; player_w = 10'd40; player_h = 10'd30;
    box_x_pos = 10'd120; box_y_pos = 10'd285; box_width = 10'd20; box_height = 10'd20;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_defaults();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    set_defaults();
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_vec !== 22'd0) $display("FAIL reset_state: got %h expected %h", dut_vec, 22'd0);
    else n_pass++;
    rst = 1'b1;
    step();
    n_checks++;
    if (dut_vec !== model_vec()) $display("FAIL reset_first_step: got %h expected %h", dut_vec, model_vec());
    else n_pass++;
  endtask

  task automatic test_catch_basic();
    do_reset();
    box_active = 1'b1;
    step();
    n_checks++;
    if (box_caught !== 1'b1 || held_count !== 3'd1)
      $display("FAIL catch_pulse: got caught=%0b held=%0d expected caught=1 held=1", box_caught, held_count);
    else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) box_active = 1'b0;
      step();
      n_checks++;
      if (box_caught !== 1'b0 || dut_vec !== model_vec())
        $display("FAIL catch_cooldown step %0d: got %h expected %h", i, dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_touch_edge();
    do_reset();
    box_x_pos  = 10'd140;   // exactly touching the right edge of the player
    box_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (box_caught !== 1'b0) $display("FAIL touch_no_hit: got caught=%0b expected 0", box_caught);
      else n_pass++;
    end
    box_x_pos = 10'd139;
    step();
    n_checks++;
    if (box_caught !== 1'b1) $display("FAIL overlap_1px: got caught=%0b expected 1", box_caught);
    else n_pass++;
    // Far right border: edge sums exceed 10 bits and must not wrap.
    do_reset();
    player_x = 10'd1000; box_x_pos = 10'd1010; box_active = 1'b1;
    step();
    n_checks++;
    if (box_caught !== 1'b1 || dut_vec !== model_vec())
      $display("FAIL border_hit: got %h expected %h", dut_vec, model_vec());
    else n_pass++;
  endtask

  task automatic catch_one(input string tag);
    box_active = 1'b1;
    step();
    n_checks++;
    if (dut_vec !== model_vec()) $display("FAIL %s_catch: got %h expected %h", tag, dut_vec, model_vec());
    else n_pass++;
    box_active = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (dut_vec !== model_vec()) $display("FAIL %s_wait: got %h expected %h", tag, dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_capacity();
    do_reset();
    for (int k = 0; k < 3; k++) catch_one("capacity");
    n_checks++;
    if (held_count !== 3'd3 || player_is_holding_box !== 1'b1)
      $display("FAIL full_flag: got held=%0d holding=%0b expected held=3 holding=1", held_count, player_is_holding_box);
    else n_pass++;
    box_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (box_caught !== 1'b0 || held_count !== 3'd3)
        $display("FAIL full_ignore step %0d: got caught=%0b held=%0d expected caught=0 held=3", i, box_caught, held_count);
      else n_pass++;
    end
    box_active = 1'b0;
  endtask

  task automatic test_deposit();
    do_reset();
    catch_one("deposit");
    catch_one("deposit");
    player_x = 10'd10;
    for (int i = 1; i <= 30; i++) begin
      step();
      n_checks++;
      if (deposit_pulse !== ((i == 15) || (i == 30)) || dut_vec !== model_vec())
        $display("FAIL deposit_cycle %0d: got %h expected %h", i, dut_vec, model_vec());
      else n_pass++;
    end
    n_checks++;
    if (score !== 16'd2 || held_count !== 3'd0)
      $display("FAIL deposit_total: got score=%0d held=%0d expected score=2 held=0", score, held_count);
    else n_pass++;
    // Leave the zone one cycle short; dwell must restart from zero.
    player_x = 10'd100;
    catch_one("deposit");
    player_x = 10'd10;
    repeat (14) step();
    player_x = 10'd100;
    step();
    player_x = 10'd10;
    for (int i = 1; i <= 15; i++) begin
      step();
      n_checks++;
      if (deposit_pulse !== (i == 15) || dut_vec !== model_vec())
        $display("FAIL partial_dwell %0d: got %h expected %h", i, dut_vec, model_vec());
      else n_pass++;
    end
    n_checks++;
    if (score !== 16'd3) $display("FAIL partial_score: got %0d expected 3", score);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    catch_one("b2b");
    player_x  = 10'd10;
    box_x_pos = 10'd20;
    repeat (14) step();
    box_active = 1'b1;
    step();
    n_checks++;
    if (box_caught !== 1'b1 || deposit_pulse !== 1'b1 || held_count !== 3'd1 || score !== 16'd1)
      $display("FAIL same_edge: got caught=%0b dep=%0b held=%0d score=%0d expected 1 1 1 1",
               box_caught, deposit_pulse, held_count, score);
    else n_pass++;
    box_active = 1'b0;
  endtask

  task automatic test_game_en();
    do_reset();
    box_active = 1'b1;
    step();
    box_active = 1'b0;
    repeat (3) step();
    game_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      n_checks++;
      if (held_count !== 3'd1 || box_caught !== 1'b0 || dut_vec !== model_vec())
        $display("FAIL freeze %0d: got %h expected %h", i, dut_vec, model_vec());
      else n_pass++;
    end
    game_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      box_active = ((i >= 5 && i < 11) || i >= 17);
      step();
      n_checks++;
      if (dut_vec !== model_vec()) $display("FAIL resume %0d: got %h expected %h", i, dut_vec, model_vec());
      else n_pass++;
    end
    // Asynchronous reset right after a catch edge drops the pulse immediately.
    do_reset();
    box_active = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec !== 22'd0) $display("FAIL async_reset: got %h expected %h", dut_vec, 22'd0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    box_active = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      game_en    = ($urandom_range(0, 9) != 0);
      box_active = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 19) == 0) player_x = 10'($urandom_range(0, 160));
      if ($urandom_range(0, 3) == 0) begin
        box_x_pos  = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 220));
        box_y_pos  = 10'($urandom_range(250, 330));
        box_width  = 10'($urandom_range(0, 40));
        box_height = 10'($urandom_range(0, 40));
        player_w   = 10'($urandom_range(0, 60));
        player_h   = 10'($urandom_range(0, 40));
      end
      step();
      n_checks++;
      if (dut_vec !== model_vec()) $display("FAIL random %0d: got %h expected %h", i, dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_catch_basic();
    test_touch_edge();
    test_capacity();
    test_deposit();
    test_back_to_back();
    test_game_en();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/box_catch_inventory.md
Name: box_catch_inventory

Overview:
- Player-side counterpart of the collectible spawner. Detects when the player sprite overlaps an active flying box and issues the one-cycle `box_caught` pulse back to the spawner.
- Tracks how many boxes the player carries, up to CAPACITY, and drives `player_is_holding_box` when the player is full.
- Banks carried boxes into `score` while the player dwells in the drop zone at the left edge of the screen.
- Sits in top between player movement and the collectible spawner, and feeds the score display.

Parameters:
- CAPACITY, 3'd3: maximum boxes held. Legal range 1..7.
- CATCH_COOLDOWN, 8'd10: cycles after a catch during which no new catch is accepted.
- DROP_X_MAX, 10'd60: the player is in the drop zone when player_x < DROP_X_MAX.
- DEPOSIT_CYCLES, 8'd15: continuous in-zone cycles needed to bank one box.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- game_en  input  1  advance enable; when low, all state freezes
- box_active  input  1  spawner box is on screen
- box_x_pos  input  10  box left edge
- box_y_pos  input  10  box top edge
- box_width  input  10  box width
- box_height  input  10  box height
- player_x  input  10  player left edge
- player_y  input  10  player top edge
- player_w  input  10  player width
- player_h  input  10  player height
- box_caught  output  1  one-cycle catch pulse to the spawner
- player_is_holding_box  output  1  high when held_count == CAPACITY
- held_count  output  3  boxes currently carried
- score  output  16  banked boxes, saturating
- deposit_pulse  output  1  one-cycle pulse per banked box

Behaviour:
- Reset (rst=0, async):
  - state=S_READY.
  - box_caught=0, deposit_pulse=0, held_count=0, score=0.
  - Cooldown and dwell counters = 0.
  - player_is_holding_box=0.
- Overlap (combinational):
  - All edge sums use 11-bit arithmetic, so no wrap.
  - hit = box_active && (box_x_pos < player_x+player_w) && (player_x < box_x_pos+box_width) && (box_y_pos < player_y+player_h) && (player_y < box_y_pos+box_height).
  - Touching edges do not count as a hit.
- player_is_holding_box = (held_count == CAPACITY). It is combinational from the held_count register.
- game_en=0:
  - No register changes.
  - box_caught and deposit_pulse are forced 0 on the next edge and held 0.
- State machine (advances only when game_en=1):
  - S_READY: if hit and not full, go to S_CAUGHT. The same edge sets box_caught=1 and held_count+1. Catch latency is 1 cycle from hit sampled to pulse.
  - S_CAUGHT: exactly one cycle. Clears box_caught, loads cooldown=0, then goes to S_COOLDOWN.
  - S_COOLDOWN: cooldown increments each cycle. Return to S_READY only when cooldown == CATCH_COOLDOWN and box_active=0. Otherwise hold.
  - This prevents double-counting while the spawner leaves its flying state and drops active.
- Full: hit while held_count == CAPACITY is ignored. box_caught stays 0, the box keeps flying, and the state stays S_READY.
- Deposit (independent of the catch FSM):
  - Dwell counter increments while player_x < DROP_X_MAX and held_count > 0. Otherwise it clears to 0.
  - When dwell reaches DEPOSIT_CYCLES-1 and increments: held_count-1, score+1, deposit_pulse=1 for one cycle, dwell=0.
  - Leaving the zone mid-count clears dwell with no partial credit.
- Catch and deposit on the same edge: both apply, so held_count is net unchanged, score+1, and both pulses assert.
- Score saturation: score holds at 16'hFFFF. deposit_pulse still fires and held_count still decrements.
- Async reset mid-operation: immediate return to reset values. Any pulse in flight is dropped.
- held_count never exceeds CAPACITY and never underflows below 0.

Test Plan:
- Reset, then place the player at (100,285,40,30) with a box at x=120, y=285, active=1 → box_caught=1 on the next edge only, held_count=1, then 10 cycles in S_COOLDOWN with no further pulse while active is held for 3 more cycles.
- Box edge exactly touching the player (box_x_pos = player_x+player_w) → no box_caught. Move the box 1 px left → box_caught pulses.
- Catch 3 boxes with CAPACITY=3 → player_is_holding_box=1. A 4th overlapping box yields no pulse and held_count stays 3.
- Hold 2 boxes with player_x=10 for 30 cycles → deposit_pulse on cycles 15 and 30, score=2, held_count=0. Leaving at cycle 14 → score unchanged and dwell cleared.
- Catch while dwelling so both events land on the same edge → held_count unchanged, score+1, box_caught=1 and deposit_pulse=1 together.
- Drop game_en during S_COOLDOWN for 50 cycles → counters frozen. Assert rst mid-cooldown → all outputs return to 0 immediately.
